// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle between a requesting unit and the serial BCD adder.
// The master drives the request and the operands. The slave returns the sum
// together with its status flags.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   in1;
  logic [4*DIGITS-1:0]   in2;
  logic [4*DIGITS-1:0]   S;
  logic                  cOut;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, in1, in2,
    input  S, cOut, busy, done, err
  );

  modport slave (
    input  start, in1, in2,
    output S, cOut, busy, done, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder controller. A single one-digit BCD add stage is
// reused once per clock, starting with the least significant digit. The
// decimal carry is held in a register between cycles. Operands are latched
// when the request is accepted, so the requester may change them afterwards.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_serial_add_ctrl_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic [W-1:0]    s_reg, s_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            carry_reg, carry_next;
  logic            cout_reg, cout_next;
  logic            err_reg, err_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  logic [DIGITS-1:0] dig_sel;
  logic [3:0]        a_dig, b_dig, sum_dig;
  logic [4:0]        z;
  logic              carry_new, dig_bad, last_dig;

  // One-hot decode of the digit counter, which selects the current digit.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
    assign dig_sel[gi] = (cnt_reg == CW'(gi));
  end

  assign last_dig = (cnt_reg == CW'(DIGITS - 1));

  // Select the current operand digits using an AND-OR mux over the counter decode.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_sel[k]) begin
        a_dig = a_reg[k*4 +: 4];
        b_dig = b_reg[k*4 +: 4];
      end
    end
  end

  // Add one BCD digit. Adding 6 skips the six unused codes. Invalid digits still follow the same rule.
  always_comb begin
    z         = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_reg};
    carry_new = (z > 5'd9);
    sum_dig   = carry_new ? (z[3:0] + 4'd6) : z[3:0];
    dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
  end

  // Compute the next state and the datapath updates. Every next value first defaults to holding.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.in1;
          b_next     = bus.in2;
          s_next     = '0;
          cnt_next   = '0;
          carry_next = 1'b0;
          cout_next  = 1'b0;
          err_next   = 1'b0;
          state_next = ADD;
        end
      end
      ADD: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (dig_sel[k]) s_next[k*4 +: 4] = sum_dig;
        end
        carry_next = carry_new;
        if (dig_bad) err_next = 1'b1;
        if (last_dig) begin
          cout_next  = carry_new;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == ADD);
    done_next = (state_next == DONE);
  end

  // Register the state and all outputs. Reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      s_reg     <= s_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      err_reg   <= err_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.S    = s_reg;
  assign bus.cOut = cout_reg;
  assign bus.err  = err_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for the serial BCD adder controller. It uses a 4-digit
// instance for the table vectors and the multi-cycle sequences. It uses a
// 2-digit instance for the digit-pair sweep.
module tb_bcd_serial_add_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bcd_serial_add_ctrl_if #(.DIGITS(4)) bus4 ();
  bcd_serial_add_ctrl_if #(.DIGITS(2)) bus2 ();

  bcd_serial_add_ctrl #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  bcd_serial_add_ctrl #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
    logic        e;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Run one 4-digit operation with start in cycle 0, and check the busy/done timing through cycle 6.
  task automatic run_op4(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] s, input logic c, input logic e);
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.in1 = a; bus4.in2 = b;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus4.start = 1'b0;
      @(negedge clk);
      check({name, " busy"}, 32'(bus4.busy), 32'(cyc <= 4));
      check({name, " done"}, 32'(bus4.done), 32'(cyc == 5));
      if (cyc == 5) begin
        check({name, " S"}, 32'(bus4.S), 32'(s));
        check({name, " cOut"}, 32'(bus4.cOut), 32'(c));
        check({name, " err"}, 32'(bus4.err), 32'(e));
      end
    end
    $display("op %s: %h + %h -> S=%h cOut=%0d err=%0d", name, a, b, bus4.S, bus4.cOut, bus4.err);
  endtask

  // Run one 2-digit operation. Done is expected in cycle 3, and the result is checked against the decimal reference.
  task automatic run_op2(input int av, input int bv, input logic [7:0] a, input logic [7:0] b);
    int sum;
    sum = av + bv;
    @(posedge clk); #1;
    bus2.start = 1'b1; bus2.in1 = a; bus2.in2 = b;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus2.start = 1'b0;
      @(negedge clk);
      check("d2 done", 32'(bus2.done), 32'(cyc == 3));
      if (cyc == 3) begin
        check("d2 S", 32'(bus2.S), 32'(to_bcd2(sum % 100)));
        check("d2 cOut", 32'(bus2.cOut), 32'(sum >= 100));
      end
    end
    $display("d2 %h + %h -> S=%h cOut=%0d", a, b, bus2.S, bus2.cOut);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.in1 = '0; bus4.in2 = '0;
    bus2.start = 1'b0; bus2.in1 = '0; bus2.in2 = '0;

    vecs[0] = '{"basic",   16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{"ripple",  16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"zero",    16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{"baddig",  16'h00A5, 16'h0005, 16'h0110, 1'b0, 1'b1};
    vecs[4] = '{"errclr",  16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0};
    vecs[5] = '{"max",     16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0};
    vecs[6] = '{"topcar",  16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{"badtop",  16'hF000, 16'h0000, 16'h5000, 1'b1, 1'b1};
    vecs[8] = '{"lowcar",  16'h0009, 16'h0001, 16'h0010, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst S", 32'(bus4.S), 32'h0);
    check("rst cOut", 32'(bus4.cOut), 32'h0);
    check("rst err", 32'(bus4.err), 32'h0);
    check("rst busy", 32'(bus4.busy), 32'h0);
    check("rst done", 32'(bus4.done), 32'h0);
    check("rst d2 S", 32'(bus2.S), 32'h0);
    $display("reset: S=%h cOut=%0d err=%0d busy=%0d done=%0d", bus4.S, bus4.cOut, bus4.err, bus4.busy, bus4.done);

    for (int i = 0; i < 9; i++) begin
      run_op4(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].e);
    end

    // Hold start high and change the operands in cycle 2. The second start is taken in cycle 6, so its done arrives in cycle 11.
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.in1 = 16'h1234; bus4.in2 = 16'h5678;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) begin
        bus4.in1 = 16'h9999; bus4.in2 = 16'h9999;
      end
      @(negedge clk);
      check("hold busy", 32'(bus4.busy), 32'((cyc >= 1 && cyc <= 4) || (cyc >= 7 && cyc <= 10)));
      check("hold done", 32'(bus4.done), 32'(cyc == 5 || cyc == 11));
      if (cyc == 5) begin
        check("hold S1", 32'(bus4.S), 32'h6912);
        check("hold cOut1", 32'(bus4.cOut), 32'h0);
      end
      if (cyc == 11) begin
        check("hold S2", 32'(bus4.S), 32'h9998);
        check("hold cOut2", 32'(bus4.cOut), 32'h1);
        check("hold err2", 32'(bus4.err), 32'h0);
        bus4.start = 1'b0;
      end
    end
    $display("seq held-start: final S=%h cOut=%0d", bus4.S, bus4.cOut);

    // Assert reset in cycle 2 of an operation. The state is cleared the next cycle, and no done pulse follows.
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.in1 = 16'h000B; bus4.in2 = 16'h0000;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus4.start = 1'b0;
      if (cyc == 2) rst = 1'b1;
      if (cyc == 3) rst = 1'b0;
      @(negedge clk);
      if (cyc == 2) begin
        check("abort pre S", 32'(bus4.S), 32'h0001);
        check("abort pre err", 32'(bus4.err), 32'h1);
        check("abort pre busy", 32'(bus4.busy), 32'h1);
      end
      if (cyc == 3) begin
        check("abort S", 32'(bus4.S), 32'h0);
        check("abort cOut", 32'(bus4.cOut), 32'h0);
        check("abort err", 32'(bus4.err), 32'h0);
        check("abort busy", 32'(bus4.busy), 32'h0);
      end
      if (cyc >= 3) check("abort done", 32'(bus4.done), 32'h0);
    end
    $display("seq mid-op reset: S=%h busy=%0d err=%0d", bus4.S, bus4.busy, bus4.err);
    run_op4("after_rst", 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0);

    // Two-digit sweep. First cover all low-digit pairs. Then cover all high-digit pairs, once with and once without a carry out of digit 0.
    for (int al = 0; al < 10; al++) begin
      for (int bl = 0; bl < 10; bl++) begin
        run_op2(al, bl, {4'h0, 4'(al)}, {4'h0, 4'(bl)});
      end
    end
    for (int ah = 0; ah < 10; ah++) begin
      for (int bh = 0; bh < 10; bh++) begin
        run_op2(ah * 10, bh * 10, {4'(ah), 4'h0}, {4'(bh), 4'h0});
        run_op2(ah * 10 + 9, bh * 10 + 1, {4'(ah), 4'h9}, {4'(bh), 4'h1});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
